v60_prefetch_queue: RTL and testbench
=====================================

V60_PREFETCH_QUEUE -- requirements
Module: v60_prefetch_queue

Interface
REQ-001 Parameter QUEUE_BYTES, default 16: byte capacity of the queue; power of two, at least 8.
REQ-002 Parameter WINDOW_BYTES, default 6: width of the decode window in bytes; at most QUEUE_BYTES-4.
REQ-003 Parameter ADDR_WIDTH, default 32: width of the fetch address.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port fetch_en, input, 1: when low, no new memory request is issued.
REQ-007 Port flush, input, 1: discard all queue contents and redirect fetch.
REQ-008 Port flush_pc, input, ADDR_WIDTH: byte address to redirect fetch to; any alignment.
REQ-009 Port mem_req, output, 1: word read request, registered.
REQ-010 Port mem_addr, output, ADDR_WIDTH: word-aligned read address, registered.
REQ-011 Port mem_rdata, input, 32: read data; byte 0 is bits [7:0].
REQ-012 Port mem_ready, input, 1: request completes this cycle and mem_rdata is valid.
REQ-013 Port win_data, output, 8*WINDOW_BYTES: window bytes starting at the queue head; byte i is bits [8i+7:8i].
REQ-014 Port win_valid, output, clog2(WINDOW_BYTES+1): number of valid window bytes, equal to min(count, WINDOW_BYTES).
REQ-015 Port win_pc, output, ADDR_WIDTH: address of window byte 0.
REQ-016 Port consume, input, 1: remove consume_len bytes from the head.
REQ-017 Port consume_len, input, clog2(WINDOW_BYTES+1): number of bytes to remove.
REQ-018 Port consume_err, output, 1: one-cycle pulse when consume_len exceeds win_valid.

Function
REQ-019 The block SHALL be a byte ring buffer with read pointer, write pointer and count; pointers SHALL wrap modulo QUEUE_BYTES.
REQ-020 FSM states SHALL be IDLE, REQ and DRAIN.
REQ-021 IDLE -> REQ when fetch_en is high, flush is low and free space minus 4 is at least 0; mem_req SHALL be set on the following edge.
REQ-022 In REQ, mem_req and mem_addr SHALL hold stable until mem_ready; at most one request SHALL be outstanding.
REQ-023 REQ with mem_ready: write bytes (mem_addr[1:0] skip)..3 of mem_rdata; advance fetch address by 4; return to IDLE, or stay in REQ with the next address if the space rule still holds.
REQ-024 Skip SHALL equal flush_pc[1:0] for the first word after a flush, and 0 otherwise.
REQ-025 Fill data accepted in cycle N SHALL appear in win_data/win_valid at cycle N+1.
REQ-026 Consume with consume_len <= win_valid SHALL advance rd_ptr and win_pc by consume_len on the same edge.
REQ-027 consume_len = 0 SHALL be a no-op.
REQ-028 Consume with consume_len > win_valid SHALL be ignored and SHALL pulse consume_err.
REQ-029 Simultaneous fill and consume SHALL both apply; count_next = count + written - consumed.
REQ-030 The space check SHALL use count after the same-cycle consume; the queue SHALL never overflow.
REQ-031 Flush SHALL have priority over fill and consume: count <- 0, win_pc <- flush_pc, fetch address <- {flush_pc[ADDR_WIDTH-1:2], 2'b00}.
REQ-032 Flush while in REQ without mem_ready SHALL go to DRAIN: the old request is held until mem_ready, its data discarded, then REQ at the new address.
REQ-033 Flush in the same cycle as mem_ready SHALL discard that data.
REQ-034 A second flush during DRAIN SHALL update the redirect address only.
REQ-035 fetch_en low SHALL NOT abort an outstanding request.
REQ-036 Bytes beyond win_valid in win_data SHALL be driven 0.

Reset
REQ-037 On rst_n low, asynchronously: state IDLE, count 0, pointers 0, mem_req 0, mem_addr 0, win_pc 0, consume_err 0, skip 0.
REQ-038 Reset asserted mid-request SHALL drop mem_req immediately, with no drain.
REQ-039 The first request after reset SHALL be at address 0.

Structure
REQ-040 The FSM state enum and the default QUEUE_BYTES/WINDOW_BYTES constants SHALL live in the shared v60 package.
REQ-041 A single sub-module, v60_byte_ring, SHALL hold the storage, pointers and window extraction; the FSM and address logic SHALL stay in the top level.

Verification
REQ-042 Reset, fetch_en=1, memory returns 0x44332211 with mem_ready one cycle after request -> mem_addr=0, then win_valid=4, win_data[31:0]=0x44332211, win_pc=0.
REQ-043 flush_pc=0x103 -> mem_addr=0x100; data 0xDDCCBBAA gives win_valid=1, byte0=0xDD, win_pc=0x103.
REQ-044 Consumer idle, memory always ready, QUEUE_BYTES=16 -> exactly 4 fills, count=16, mem_req low; consume 6 -> exactly one further fill.
REQ-045 Flush asserted while mem_ready is held off 3 cycles -> old address held to completion, data discarded, next mem_addr is the flush target.
REQ-046 win_valid=2 with consume_len=3 -> consume_err pulses one cycle, count unchanged; consume_len=2 with same-cycle fill -> count=4.
REQ-047 Random consume/flush/ready-delay soak against a byte-array model -> win_data and win_pc always match, no overflow.

Source files
------------

// File: rtl/v60_pkg.sv
// Shared types and defaults for the v60 instruction prefetch queue.
// Imported by the byte ring and the prefetch top level.
package v60_pkg;

  localparam int V60_QUEUE_BYTES  = 16;
  localparam int V60_WINDOW_BYTES = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } pq_state_e;

  // Bytes of a fetched word that land in the queue.
  function automatic logic [2:0] fill_bytes(
    input logic [1:0] skip
  );
    return 3'd4 - {1'b0, skip};
  endfunction

endpackage

// File: rtl/v60_byte_ring.sv
// Byte ring buffer with word-wide fill, variable-length consume
// and a zero-padded decode window at the read pointer.
module v60_byte_ring
  import v60_pkg::*;
#(
  parameter int QUEUE_BYTES  = V60_QUEUE_BYTES,
  parameter int WINDOW_BYTES = V60_WINDOW_BYTES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               wr_en,
  input  logic [31:0]                        wr_data,
  input  logic [1:0]                         wr_skip,
  input  logic                               rd_en,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]  rd_len,
  output logic [$clog2(QUEUE_BYTES+1)-1:0]   count_nxt,
  output logic [8*WINDOW_BYTES-1:0]          win_data,
  output logic [$clog2(WINDOW_BYTES+1)-1:0]  win_valid
);

  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = $clog2(QUEUE_BYTES+1);
  localparam int LW = $clog2(WINDOW_BYTES+1);

  logic [7:0]    mem [QUEUE_BYTES];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    wr_n;
  logic [LW-1:0] rd_n;
  logic [PW-1:0] wr_idx [4];
  logic [3:0]    wr_be;

  always_comb begin
    wr_n = wr_en ? fill_bytes(wr_skip) : 3'd0;
    rd_n = rd_en ? rd_len : '0;
    count_nxt = clear ? '0
              : count + CW'(wr_n) - CW'(rd_n);
    // Skipped low bytes shift the rest down onto wr_ptr.
    for (int j = 0; j < 4; j++) begin
      wr_be[j]  = wr_en && !clear
               && (2'(j) >= wr_skip);
      wr_idx[j] = wr_ptr + PW'(j) - PW'(wr_skip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_BYTES; i++)
        mem[i] <= 8'h00;
    end else begin
      count <= count_nxt;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(rd_n);
        wr_ptr <= wr_ptr + PW'(wr_n);
        for (int j = 0; j < 4; j++)
          if (wr_be[j])
            mem[wr_idx[j]] <= wr_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      if (CW'(i) < count)
        win_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
    win_valid = (count > CW'(WINDOW_BYTES))
              ? LW'(WINDOW_BYTES) : LW'(count);
  end

endmodule

// File: rtl/v60_prefetch_queue.sv
// Instruction prefetch queue: word fetch FSM feeding a byte ring,
// with flush redirect and a decode window at the queue head.
module v60_prefetch_queue
  import v60_pkg::*;
#(
  parameter int QUEUE_BYTES  = V60_QUEUE_BYTES,
  parameter int WINDOW_BYTES = V60_WINDOW_BYTES,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fetch_en,
  input  logic                               flush,
  input  logic [ADDR_WIDTH-1:0]              flush_pc,
  output logic                               mem_req,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [31:0]                        mem_rdata,
  input  logic                               mem_ready,
  output logic [8*WINDOW_BYTES-1:0]          win_data,
  output logic [$clog2(WINDOW_BYTES+1)-1:0]  win_valid,
  output logic [ADDR_WIDTH-1:0]              win_pc,
  input  logic                               consume,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]  consume_len,
  output logic                               consume_err
);

  localparam int CW = $clog2(QUEUE_BYTES+1);

  pq_state_e             state;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] flush_base;
  logic [1:0]            skip;
  logic                  wr_en;
  logic                  cons_ok;
  logic                  cons_bad;
  logic                  space_ok;
  logic [CW-1:0]         count_nxt;

  assign flush_base = {flush_pc[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    wr_en    = (state == S_REQ) && mem_ready && !flush;
    cons_ok  = consume && !flush
            && (consume_len <= win_valid);
    cons_bad = consume && !flush
            && (consume_len > win_valid);
    // Room for a whole word after this edge's fill and consume.
    space_ok = count_nxt <= CW'(QUEUE_BYTES-4);
  end

  v60_byte_ring #(
    .QUEUE_BYTES  (QUEUE_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .wr_en     (wr_en),
    .wr_data   (mem_rdata),
    .wr_skip   (skip),
    .rd_en     (cons_ok),
    .rd_len    (consume_len),
    .count_nxt (count_nxt),
    .win_data  (win_data),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      fetch_addr  <= '0;
      skip        <= 2'd0;
      win_pc      <= '0;
      consume_err <= 1'b0;
    end else begin
      consume_err <= cons_bad;

      unique case (1'b1)
        flush:   win_pc <= flush_pc;
        cons_ok: win_pc <= win_pc
                         + ADDR_WIDTH'(consume_len);
        default: ;
      endcase

      if (flush) begin
        fetch_addr <= flush_base;
        skip       <= flush_pc[1:0];
      end

      unique case (state)
        S_IDLE: begin
          if (fetch_en && !flush && space_ok) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            if (flush) begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end else begin
              fetch_addr <= fetch_addr
                          + ADDR_WIDTH'(4);
              skip       <= 2'd0;
              if (fetch_en && space_ok)
                mem_addr <= fetch_addr
                          + ADDR_WIDTH'(4);
              else begin
                state   <= S_IDLE;
                mem_req <= 1'b0;
              end
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        // Stale request completes; its data never enters the ring.
        S_DRAIN: begin
          if (mem_ready) begin
            state    <= S_REQ;
            mem_addr <= flush ? flush_base
                              : fetch_addr;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Bench for v60_prefetch_queue: directed scenarios plus a random
// soak, checked every cycle against a contiguous-byte model.
module tb_v60_prefetch_queue;

  localparam int QB = 16;
  localparam int WB = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic [47:0] win_data;
  logic [2:0]  win_valid;
  logic [31:0] win_pc;
  logic        consume = 1'b0;
  logic [2:0]  consume_len = '0;
  logic        consume_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_hash(input logic [31:0] a);
    logic [31:0] t;
    t = (a * 32'd7) ^ (a >> 8) ^ 32'hC3;
    return t[7:0];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w == 32'h0)   return 32'h44332211;
    if (w == 32'h100) return 32'hDDCCBBAA;
    return {mem_hash(w+3), mem_hash(w+2),
            mem_hash(w+1), mem_hash(w)};
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[8*a[1:0] +: 8];
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  v60_prefetch_queue #(
    .QUEUE_BYTES  (QB),
    .WINDOW_BYTES (WB),
    .ADDR_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .win_data    (win_data),
    .win_valid   (win_valid),
    .win_pc      (win_pc),
    .consume     (consume),
    .consume_len (consume_len),
    .consume_err (consume_err)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within bound", nm);
  endtask

  // Memory responder: ready after `lat` waiting cycles.
  int lat = 1;
  bit always_ready = 1'b0;
  int rcnt = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ready = 1'b0;
      rcnt = 0;
    end else if (always_ready) begin
      mem_ready = 1'b1;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      rcnt = 0;
    end else if (mem_req) begin
      if (rcnt >= lat) mem_ready = 1'b1;
      else rcnt++;
    end
  end

  // Model: queue holds the memory bytes [m_pc, m_pc+m_cnt).
  logic [31:0] m_pc = '0;
  int          m_cnt = 0;
  bit          m_stale = 1'b0;
  bit          m_err = 1'b0;
  bit          p_pend = 1'b0;
  logic [31:0] p_addr = '0;
  int          e_valid;
  logic [47:0] e_data;
  logic [31:0] e_next;
  int          e_add;
  bit          e_hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = '0; m_cnt = 0; m_stale = 0;
      m_err = 0; p_pend = 0;
      check("rst_mem_req", mem_req, 0);
      check("rst_win_valid", win_valid, 0);
    end else begin
      e_valid = (m_cnt < WB) ? m_cnt : WB;
      e_data = '0;
      for (int i = 0; i < e_valid; i++)
        e_data[8*i +: 8] = mem_byte(m_pc + i);
      check("win_valid", win_valid, e_valid);
      check("win_pc", win_pc, m_pc);
      check("win_data", win_data, e_data);
      check("consume_err", consume_err, m_err);
      if (p_pend) begin
        check("hold_req", mem_req, 1);
        check("hold_addr", mem_addr, p_addr);
      end
      e_hs = mem_req && mem_ready;
      e_add = 0;
      m_err = consume && !flush && (consume_len > e_valid);
      p_pend = mem_req && !mem_ready;
      p_addr = mem_addr;
      if (flush) begin
        m_stale = e_hs ? 1'b0 : mem_req;
        m_pc = flush_pc;
        m_cnt = 0;
      end else begin
        if (e_hs && m_stale) begin
          m_stale = 1'b0;
        end else if (e_hs) begin
          e_next = m_pc + m_cnt;
          check("fill_addr", mem_addr, e_next & ~32'h3);
          e_add = 4 - int'(e_next[1:0]);
        end
        if (consume && consume_len <= e_valid) begin
          m_pc = m_pc + consume_len;
          m_cnt = m_cnt - consume_len;
        end
        m_cnt = m_cnt + e_add;
        check("no_overflow", m_cnt <= QB, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 30 && !mem_req; i++) tick();
    if (!mem_req) timeout(nm);
  endtask

  task automatic wait_hs(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && mem_ready) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) timeout(nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 30 && mem_req; i++) tick();
    if (mem_req) timeout(nm);
  endtask

  int fills;

  initial begin
    tick();
    tick();
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_win_valid", win_valid, 0);
    check("reset_win_pc", win_pc, 0);
    check("reset_consume_err", consume_err, 0);

    // First word after reset.
    rst_n = 1'b1;
    fetch_en = 1'b1;
    wait_req("t1_req");
    check("t1_addr", mem_addr, 32'h0);
    wait_hs("t1_hs");
    check("t1_valid", win_valid, 4);
    check("t1_data", win_data[31:0], 32'h44332211);
    check("t1_pc", win_pc, 32'h0);
    fetch_en = 1'b0;
    wait_idle("t1_idle");
    check("t1_outstanding_done", win_valid, 6);

    // Unaligned redirect.
    flush = 1'b1;
    flush_pc = 32'h103;
    fetch_en = 1'b1;
    tick();
    flush = 1'b0;
    wait_req("t2_req");
    check("t2_addr", mem_addr, 32'h100);
    wait_hs("t2_hs");
    check("t2_valid", win_valid, 1);
    check("t2_byte0", win_data[7:0], 8'hDD);
    check("t2_pad", win_data[47:8], 0);
    check("t2_pc", win_pc, 32'h103);
    fetch_en = 1'b0;
    wait_idle("t2_idle");

    // Consume errors and consume-with-fill (5 bytes queued).
    consume = 1'b1;
    consume_len = 3'd3;
    tick();
    consume = 1'b0;
    check("t3_valid", win_valid, 2);
    check("t3_pc", win_pc, 32'h106);
    consume = 1'b1;
    consume_len = 3'd3;
    tick();
    consume = 1'b0;
    check("t3_err", consume_err, 1);
    check("t3_err_keep", win_valid, 2);
    tick();
    check("t3_err_pulse", consume_err, 0);
    fetch_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && mem_ready) begin
        consume = 1'b1;
        consume_len = 3'd2;
        break;
      end
      tick();
    end
    tick();
    consume = 1'b0;
    check("t3_fill_consume", win_valid, 4);
    check("t3_fill_pc", win_pc, 32'h108);
    fetch_en = 1'b0;
    wait_idle("t3_idle");

    // Fill to capacity with an idle consumer.
    always_ready = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h200;
    fetch_en = 1'b1;
    tick();
    flush = 1'b0;
    fills = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_ready) fills++;
      tick();
    end
    check("t4_fills", fills, 4);
    check("t4_req_low", mem_req, 0);
    check("t4_valid", win_valid, 6);
    consume = 1'b1;
    consume_len = 3'd6;
    tick();
    consume = 1'b0;
    fills = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_ready) fills++;
      tick();
    end
    check("t4_refill", fills, 1);
    check("t4_req_low2", mem_req, 0);
    always_ready = 1'b0;
    tick();

    // Flush while a slow request is outstanding.
    lat = 3;
    flush = 1'b1;
    flush_pc = 32'h400;
    tick();
    flush = 1'b0;
    wait_req("t5_req");
    check("t5_addr", mem_addr, 32'h400);
    flush = 1'b1;
    flush_pc = 32'h555;
    tick();
    flush_pc = 32'h601;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req && mem_ready) begin
        tick();
        break;
      end
      check("t5_drain_hold", mem_addr, 32'h400);
      tick();
    end
    check("t5_req_on", mem_req, 1);
    check("t5_new_addr", mem_addr, 32'h600);
    check("t5_discard", win_valid, 0);
    check("t5_pc", win_pc, 32'h601);

    // Reset mid-request drops the request at once.
    rst_n = 1'b0;
    #1;
    check("t6_async_req", mem_req, 0);
    check("t6_async_addr", mem_addr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    lat = 1;
    wait_req("t6_req");
    check("t6_first_addr", mem_addr, 32'h0);

    // Random soak.
    for (int c = 0; c < 2000; c++) begin
      lat = $urandom_range(0, 3);
      fetch_en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      flush_pc = $urandom;
      consume = ($urandom_range(0, 1) == 1);
      consume_len = 3'($urandom_range(0, WB));
      tick();
    end
    flush = 1'b0;
    consume = 1'b0;
    fetch_en = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
